// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: one single-port frame-buffer BRAM shared by scan-out reads and queued pixel writes.
// Latency: grant to mem_* is 1 cycle; display slot to pixel_out/hcount_out/vcount_out/ad_out is RD_LATENCY+2 cycles.
// Backpressure: wr_ready_out drops only while the write queue is full; display reads are never stalled.

module frame_mem_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign dout = store[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= din;
    end
endmodule

module frame_mem_arbiter #(
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int ACTIVE_LINES    = 720,
    parameter int TOTAL_PIXELS    = 1650,
    parameter int TOTAL_LINES     = 750,
    parameter int SCALE           = 4,
    parameter int FB_WIDTH        = 320,
    parameter int FB_HEIGHT       = 180,
    parameter int DATA_W          = 16,
    parameter int RD_LATENCY      = 2,
    parameter int WQ_DEPTH        = 8,
    localparam int AW = $clog2(FB_WIDTH * FB_HEIGHT),
    localparam int HW = $clog2(TOTAL_PIXELS),
    localparam int VW = $clog2(TOTAL_LINES),
    localparam int LW = $clog2(WQ_DEPTH) + 1
) (
    input  logic              pixel_clk_in,
    input  logic              rst_n_in,
    input  logic [HW-1:0]     hcount_in,
    input  logic [VW-1:0]     vcount_in,
    input  logic              wr_valid_in,
    input  logic [AW-1:0]     wr_addr_in,
    input  logic [DATA_W-1:0] wr_data_in,
    output logic              wr_ready_out,
    output logic              mem_en_out,
    output logic              mem_we_out,
    output logic [AW-1:0]     mem_addr_out,
    output logic [DATA_W-1:0] mem_din_out,
    input  logic [DATA_W-1:0] mem_dout_in,
    output logic [DATA_W-1:0] pixel_out,
    output logic [HW-1:0]     hcount_out,
    output logic [VW-1:0]     vcount_out,
    output logic              ad_out,
    output logic [LW-1:0]     wq_level_out,
    output logic [7:0]        drop_count_out
);
    localparam int          SL      = $clog2(SCALE);
    localparam int          PIPE    = RD_LATENCY + 2;
    localparam int unsigned FB_SIZE = FB_WIDTH * FB_HEIGHT;
    localparam logic [HW-1:0] H_ACT = HW'(ACTIVE_H_PIXELS);
    localparam logic [VW-1:0] V_ACT = VW'(ACTIVE_LINES);

    typedef struct packed {
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    wr_req_t           wq_in;
    wr_req_t           wq_head;
    logic              wq_push;
    logic              wq_pop;
    logic              wr_in_range;
    logic              disp_act;
    logic              disp_slot;
    logic [VW-1:0]     fb_y;
    logic [HW-1:0]     fb_x;
    logic [AW-1:0]     rd_addr;
    logic [RD_LATENCY:0] rd_tag;
    logic [HW-1:0]     h_dly [PIPE];
    logic [VW-1:0]     v_dly [PIPE];
    logic [PIPE-1:0]   a_dly;

    assign disp_act  = (hcount_in < H_ACT) && (vcount_in < V_ACT);
    assign disp_slot = disp_act && (hcount_in[SL-1:0] == '0);
    assign fb_y      = vcount_in >> SL;
    assign fb_x      = hcount_in >> SL;
    assign rd_addr   = AW'(32'(fb_y) * 32'(FB_WIDTH) + 32'(fb_x));

    assign wr_ready_out = (wq_level_out < LW'(WQ_DEPTH));
    assign wr_in_range  = (32'(wr_addr_in) < FB_SIZE);
    assign wq_push      = wr_valid_in && wr_ready_out && wr_in_range;
    // Pop uses the registered level, so a fresh push is never drained in its own cycle.
    assign wq_pop       = !disp_slot && (wq_level_out != '0);
    assign wq_in        = '{addr: wr_addr_in, data: wr_data_in};

    frame_mem_fifo #(
        .WIDTH ($bits(wr_req_t)),
        .DEPTH (WQ_DEPTH)
    ) u_wq (
        .clk   (pixel_clk_in),
        .rst_n (rst_n_in),
        .push  (wq_push),
        .pop   (wq_pop),
        .din   (wq_in),
        .dout  (wq_head),
        .level (wq_level_out)
    );

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mem_en_out   <= 1'b0;
            mem_we_out   <= 1'b0;
            mem_addr_out <= '0;
            mem_din_out  <= '0;
        end else if (disp_slot) begin
            mem_en_out   <= 1'b1;
            mem_we_out   <= 1'b0;
            mem_addr_out <= rd_addr;
        end else if (wq_pop) begin
            mem_en_out   <= 1'b1;
            mem_we_out   <= 1'b1;
            mem_addr_out <= wq_head.addr;
            mem_din_out  <= wq_head.data;
        end else begin
            mem_en_out   <= 1'b0;
            mem_we_out   <= 1'b0;
        end
    end

    // Tag travels alongside the read so only display data ever lands in pixel_out.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_tag    <= '0;
            pixel_out <= '0;
        end else begin
            rd_tag <= {rd_tag[RD_LATENCY-1:0], disp_slot};
            if (rd_tag[RD_LATENCY]) pixel_out <= mem_dout_in;
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < PIPE; i++) begin
                h_dly[i] <= '0;
                v_dly[i] <= '0;
            end
            a_dly <= '0;
        end else begin
            h_dly[0] <= hcount_in;
            v_dly[0] <= vcount_in;
            for (int i = 1; i < PIPE; i++) begin
                h_dly[i] <= h_dly[i-1];
                v_dly[i] <= v_dly[i-1];
            end
            a_dly <= {a_dly[PIPE-2:0], disp_act};
        end
    end

    assign hcount_out = h_dly[PIPE-1];
    assign vcount_out = v_dly[PIPE-1];
    assign ad_out     = a_dly[PIPE-1];

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            drop_count_out <= '0;
        end else if (wr_valid_in && wr_ready_out && !wr_in_range && drop_count_out != 8'hFF) begin
            drop_count_out <= drop_count_out + 8'd1;
        end
    end
endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter with a 2-cycle BRAM model that returns the read address as data.
module tb_frame_mem_arbiter;
    localparam int AW = 16;
    localparam int HW = 11;
    localparam int VW = 10;
    localparam int DW = 16;

    logic          pixel_clk_in = 1'b0;
    logic          rst_n_in = 1'b1;
    logic [HW-1:0] hcount_in = '0;
    logic [VW-1:0] vcount_in = '0;
    logic          wr_valid_in = 1'b0;
    logic [AW-1:0] wr_addr_in = '0;
    logic [DW-1:0] wr_data_in = '0;
    logic          wr_ready_out;
    logic          mem_en_out;
    logic          mem_we_out;
    logic [AW-1:0] mem_addr_out;
    logic [DW-1:0] mem_din_out;
    logic [DW-1:0] mem_dout_in;
    logic [DW-1:0] pixel_out;
    logic [HW-1:0] hcount_out;
    logic [VW-1:0] vcount_out;
    logic          ad_out;
    logic [3:0]    wq_level_out;
    logic [7:0]    drop_count_out;

    logic [DW-1:0] bram_d1 = '0;
    logic [DW-1:0] bram_d2 = '0;

    int n_cmp = 0;
    int n_bad = 0;

    frame_mem_arbiter dut (
        .pixel_clk_in   (pixel_clk_in),
        .rst_n_in       (rst_n_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .wr_valid_in    (wr_valid_in),
        .wr_addr_in     (wr_addr_in),
        .wr_data_in     (wr_data_in),
        .wr_ready_out   (wr_ready_out),
        .mem_en_out     (mem_en_out),
        .mem_we_out     (mem_we_out),
        .mem_addr_out   (mem_addr_out),
        .mem_din_out    (mem_din_out),
        .mem_dout_in    (mem_dout_in),
        .pixel_out      (pixel_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .ad_out         (ad_out),
        .wq_level_out   (wq_level_out),
        .drop_count_out (drop_count_out)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    always_ff @(posedge pixel_clk_in) begin
        if (mem_en_out) bram_d1 <= mem_addr_out;
        bram_d2 <= bram_d1;
    end
    assign mem_dout_in = bram_d2;

    task automatic tick();
        @(posedge pixel_clk_in);
        #1;
    endtask

    task automatic set_cnt(input int h, input int v);
        hcount_in = HW'(h);
        vcount_in = VW'(v);
    endtask

    task automatic test_reset();
        #3 rst_n_in = 1'b0;
        #4;
        n_cmp++; if ({mem_en_out, mem_we_out, mem_addr_out, mem_din_out} !== '0) begin n_bad++;
            $display("FAIL por_mem: got en=%b we=%b addr=%0d din=%0d, want all 0", mem_en_out, mem_we_out, mem_addr_out, mem_din_out); end
        n_cmp++; if ({pixel_out, hcount_out, vcount_out, ad_out} !== '0) begin n_bad++;
            $display("FAIL por_pipe: got pix=%0d h=%0d v=%0d ad=%b, want all 0", pixel_out, hcount_out, vcount_out, ad_out); end
        tick(); tick();
        rst_n_in = 1'b1;
        #1;
        n_cmp++; if (wr_ready_out !== 1'b1 || wq_level_out !== 4'd0 || drop_count_out !== 8'd0) begin n_bad++;
            $display("FAIL por_queue: got rdy=%b lvl=%0d drop=%0d, want 1/0/0", wr_ready_out, wq_level_out, drop_count_out); end

        // Hold a display slot so queued writes cannot drain.
        set_cnt(8, 4);
        for (int i = 0; i < 5; i++) begin
            wr_valid_in = 1'b1; wr_addr_in = AW'(500 + i); wr_data_in = DW'(i);
            tick();
        end
        wr_valid_in = 1'b0;
        repeat (3) tick();
        n_cmp++; if (wq_level_out !== 4'd5 || pixel_out !== 16'd322 || hcount_out !== 11'd8 || ad_out !== 1'b1) begin n_bad++;
            $display("FAIL pre_reset: got lvl=%0d pix=%0d h=%0d ad=%b, want 5/322/8/1", wq_level_out, pixel_out, hcount_out, ad_out); end
        #2 rst_n_in = 1'b0;
        #1;
        n_cmp++; if ({mem_en_out, mem_we_out, mem_addr_out, mem_din_out} !== '0) begin n_bad++;
            $display("FAIL mid_reset_mem: got en=%b we=%b addr=%0d din=%0d, want all 0", mem_en_out, mem_we_out, mem_addr_out, mem_din_out); end
        n_cmp++; if ({pixel_out, hcount_out, vcount_out, ad_out} !== '0 || wq_level_out !== 4'd0) begin n_bad++;
            $display("FAIL mid_reset_pipe: got pix=%0d h=%0d v=%0d ad=%b lvl=%0d, want all 0", pixel_out, hcount_out, vcount_out, ad_out, wq_level_out); end
        tick();
        rst_n_in = 1'b1;
        set_cnt(1300, 4);
        #1;
        n_cmp++; if (wr_ready_out !== 1'b1 || wq_level_out !== 4'd0) begin n_bad++;
            $display("FAIL release: got rdy=%b lvl=%0d, want 1/0", wr_ready_out, wq_level_out); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (mem_en_out !== 1'b0) begin n_bad++;
                $display("FAIL discard_%0d: got en=%b we=%b addr=%0d, want en=0", i, mem_en_out, mem_we_out, mem_addr_out); end
        end
        n_cmp++; if (pixel_out !== 16'd0 || hcount_out !== 11'd1300) begin n_bad++;
            $display("FAIL tag_flush: got pix=%0d h=%0d, want 0/1300", pixel_out, hcount_out); end
    endtask

    task automatic test_addressing();
        int hv [5] = '{0, 4, 1276, 0, 1276};
        int vv [5] = '{0, 0, 0, 4, 719};
        int av [5] = '{0, 1, 319, 320, 57599};
        for (int i = 0; i < 5; i++) begin
            set_cnt(hv[i], vv[i]);
            tick();
            n_cmp++; if (mem_en_out !== 1'b1 || mem_we_out !== 1'b0 || mem_addr_out !== AW'(av[i])) begin n_bad++;
                $display("FAIL addr_%0d: got en=%b we=%b addr=%0d, want 1/0/%0d", i, mem_en_out, mem_we_out, mem_addr_out, av[i]); end
        end
    endtask

    task automatic test_alignment();
        for (int i = 0; i < 24; i++) begin
            set_cnt(i, 8);
            tick();
            if (i >= 3) begin
                n_cmp++; if (hcount_out !== HW'(i - 3) || vcount_out !== 10'd8 || ad_out !== 1'b1) begin n_bad++;
                    $display("FAIL align_cnt_%0d: got h=%0d v=%0d ad=%b, want %0d/8/1", i, hcount_out, vcount_out, ad_out, i - 3); end
                n_cmp++; if (pixel_out !== DW'(640 + ((i - 3) >> 2))) begin n_bad++;
                    $display("FAIL align_pix_%0d: got %0d, want %0d", i, pixel_out, 640 + ((i - 3) >> 2)); end
            end
        end
        for (int j = 0; j < 8; j++) begin
            set_cnt(1276 + j, 8);
            tick();
            if (j >= 3) begin
                n_cmp++; if (hcount_out !== HW'(1273 + j) || ad_out !== (j < 7) || pixel_out !== 16'd959) begin n_bad++;
                    $display("FAIL edge_%0d: got h=%0d ad=%b pix=%0d, want %0d/%b/959", j, hcount_out, ad_out, pixel_out, 1273 + j, j < 7); end
            end
        end
    endtask

    task automatic test_arbitration();
        set_cnt(0, 0); tick();
        set_cnt(1, 0); tick();
        set_cnt(2, 0); tick();
        set_cnt(3, 0);
        wr_valid_in = 1'b1; wr_addr_in = 16'd100; wr_data_in = 16'hABCD;
        n_cmp++; if (wr_ready_out !== 1'b1) begin n_bad++; $display("FAIL arb_ready: got %b, want 1", wr_ready_out); end
        tick();
        wr_valid_in = 1'b0;
        n_cmp++; if (wq_level_out !== 4'd1 || mem_en_out !== 1'b0) begin n_bad++;
            $display("FAIL arb_push: got lvl=%0d en=%b, want 1/0", wq_level_out, mem_en_out); end
        set_cnt(4, 0); tick();
        n_cmp++; if (mem_en_out !== 1'b1 || mem_we_out !== 1'b0 || mem_addr_out !== 16'd1 || wq_level_out !== 4'd1) begin n_bad++;
            $display("FAIL arb_slot: got en=%b we=%b addr=%0d lvl=%0d, want 1/0/1/1", mem_en_out, mem_we_out, mem_addr_out, wq_level_out); end
        set_cnt(5, 0); tick();
        n_cmp++; if (mem_we_out !== 1'b1 || mem_addr_out !== 16'd100 || mem_din_out !== 16'hABCD || wq_level_out !== 4'd0) begin n_bad++;
            $display("FAIL arb_write: got we=%b addr=%0d din=%h lvl=%0d, want 1/100/abcd/0", mem_we_out, mem_addr_out, mem_din_out, wq_level_out); end

        set_cnt(1300, 0);
        for (int i = 0; i < 8; i++) begin
            wr_valid_in = 1'b1; wr_addr_in = AW'(200 + i); wr_data_in = DW'(i + 1);
            tick();
            if (i >= 1) begin
                n_cmp++; if (mem_we_out !== 1'b1 || mem_addr_out !== AW'(199 + i) || wq_level_out !== 4'd1) begin n_bad++;
                    $display("FAIL blank_%0d: got we=%b addr=%0d lvl=%0d, want 1/%0d/1", i, mem_we_out, mem_addr_out, wq_level_out, 199 + i); end
            end
        end
        wr_valid_in = 1'b0;
        tick();
        n_cmp++; if (mem_we_out !== 1'b1 || mem_addr_out !== 16'd207 || mem_din_out !== 16'd8) begin n_bad++;
            $display("FAIL blank_last: got we=%b addr=%0d din=%0d, want 1/207/8", mem_we_out, mem_addr_out, mem_din_out); end
        tick();
        n_cmp++; if (mem_en_out !== 1'b0 || wq_level_out !== 4'd0) begin n_bad++;
            $display("FAIL blank_idle: got en=%b lvl=%0d, want 0/0", mem_en_out, wq_level_out); end
    endtask

    task automatic test_full();
        int hv [11] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
        int ev [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int wv [11] = '{1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 0};
        int av [11] = '{1002, 1, 1003, 1004, 1005, 2, 1006, 1007, 1008, 3, 3};
        set_cnt(0, 0);
        for (int i = 0; i < 9; i++) begin
            wr_valid_in = 1'b1; wr_addr_in = AW'(1000 + i); wr_data_in = DW'(i);
            n_cmp++; if (wr_ready_out !== (i < 8)) begin n_bad++;
                $display("FAIL fill_rdy_%0d: got %b, want %b", i, wr_ready_out, i < 8); end
            tick();
        end
        n_cmp++; if (wq_level_out !== 4'd8 || wr_ready_out !== 1'b0) begin n_bad++;
            $display("FAIL full: got lvl=%0d rdy=%b, want 8/0", wq_level_out, wr_ready_out); end
        set_cnt(1, 0); tick();
        n_cmp++; if (mem_we_out !== 1'b1 || mem_addr_out !== 16'd1000 || wq_level_out !== 4'd7) begin n_bad++;
            $display("FAIL full_pop: got we=%b addr=%0d lvl=%0d, want 1/1000/7", mem_we_out, mem_addr_out, wq_level_out); end
        set_cnt(2, 0); tick();
        wr_valid_in = 1'b0;
        n_cmp++; if (mem_we_out !== 1'b1 || mem_addr_out !== 16'd1001 || wq_level_out !== 4'd7) begin n_bad++;
            $display("FAIL push_pop: got we=%b addr=%0d lvl=%0d, want 1/1001/7", mem_we_out, mem_addr_out, wq_level_out); end
        for (int i = 0; i < 11; i++) begin
            set_cnt(hv[i], 0);
            tick();
            n_cmp++; if (mem_en_out !== ev[i][0] || mem_we_out !== wv[i][0] || mem_addr_out !== AW'(av[i])) begin n_bad++;
                $display("FAIL drain_h%0d: got en=%b we=%b addr=%0d, want %0d/%0d/%0d", hv[i], mem_en_out, mem_we_out, mem_addr_out, ev[i], wv[i], av[i]); end
            if (wv[i] == 1) begin
                n_cmp++; if (mem_din_out !== DW'(av[i] - 1000)) begin n_bad++;
                    $display("FAIL drain_din_h%0d: got %0d, want %0d", hv[i], mem_din_out, av[i] - 1000); end
            end
        end
    endtask

    task automatic test_drop();
        set_cnt(1300, 0);
        wr_valid_in = 1'b1; wr_addr_in = 16'd57600; wr_data_in = 16'd5;
        n_cmp++; if (wr_ready_out !== 1'b1) begin n_bad++; $display("FAIL drop_rdy: got %b, want 1", wr_ready_out); end
        tick();
        wr_valid_in = 1'b0;
        n_cmp++; if (drop_count_out !== 8'd1 || wq_level_out !== 4'd0) begin n_bad++;
            $display("FAIL drop_one: got drop=%0d lvl=%0d, want 1/0", drop_count_out, wq_level_out); end
        tick();
        n_cmp++; if (mem_en_out !== 1'b0) begin n_bad++;
            $display("FAIL drop_nowrite: got en=%b we=%b addr=%0d, want en=0", mem_en_out, mem_we_out, mem_addr_out); end
        wr_valid_in = 1'b1;
        repeat (299) tick();
        wr_valid_in = 1'b0;
        n_cmp++; if (drop_count_out !== 8'd255) begin n_bad++;
            $display("FAIL drop_sat: got %0d, want 255", drop_count_out); end
    endtask

    initial begin
        test_reset();
        test_addressing();
        test_alignment();
        test_arbitration();
        test_full();
        test_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
